cpu_alu_regfile: RTL and testbench
==================================

// Module: cpu_alu_regfile
// PURPOSE
// - Datapath core of the 8-bit CPU: a small general-purpose register file plus a registered 4-bit ALU.
// - ALU operands are read from the register file by address. The result is registered onto out/flags.
// - The result can optionally be written back to a register.
// - Sits under the CPU sequencer, which loads operands, issues opcodes and reads results.
// PARAMETERS
// - DATA_W   4  width of registers, operands and result
// - REG_NUM  4  number of registers in the file
// - ADDR_W   2  register address width; REG_NUM == 2**ADDR_W
// PORTS
// - clk        in   1       single clock, all state updates on rising edge
// - rst        in   1       synchronous, active-low reset (asserted when 0)
// - wr_en      in   1       external register write enable
// - reg_addr   in   ADDR_W  external write / debug-read address
// - reg_in     in   DATA_W  external write data
// - reg_out    out  DATA_W  combinational read of reg[reg_addr]
// - op_addr_1  in   ADDR_W  register address of operand A
// - op_addr_2  in   ADDR_W  register address of operand B
// - en         in   1       ALU issue strobe
// - opcode     in   3       ALU operation
// - wb_en      in   1       write ALU result back, qualified by en
// - wb_addr    in   ADDR_W  write-back destination register
// - out        out  DATA_W  registered ALU result
// - carry      out  1       registered carry/borrow flag
// - zero       out  1       registered zero flag
// - valid      out  1       one-cycle pulse: out/flags updated this cycle
// BEHAVIOUR
// - Reset
//   - Reset is sampled on the clk edge while rst==0.
//   - It clears all registers, out, carry, zero and valid to 0.
//   - Reset dominates wr_en, en and wb_en.
// - Register file
//   - Read is combinational; reg_out follows reg_addr in the same cycle.
//   - Write: on a clk edge with wr_en=1, reg[reg_addr] <= reg_in.
// - ALU issue
//   - Operands are A = reg[op_addr_1] and B = reg[op_addr_2], using pre-edge register contents.
//   - On a clk edge with en=1, the result is latched into out, carry and zero, and valid is set to 1.
//   - Latency: 1 cycle from en to visible out/valid.
//   - Back-to-back en on consecutive cycles is allowed, giving one result per cycle.
// - When en=0, out/carry/zero hold their previous values and valid is 0.
// - Opcodes (all arithmetic is modulo 2**DATA_W)
//   - 000 ADD: A+B; carry = bit DATA_W of the sum
//   - 001 SUB: A-B; carry = borrow (1 iff A<B)
//   - 010 AND, 011 OR, 100 XOR: carry=0
//   - 101 NOT A: ~A, carry=0
//   - 110 SHL A: A<<1, carry = A[MSB]
//   - 111 SHR A: A>>1 logical, carry = A[0]
// - Zero flag: zero = (result == 0) for every opcode.
// - Write-back: on an edge with en=1 and wb_en=1, reg[wb_addr] <= result, written at the same edge out is latched.
// - wb_en is ignored when en=0.
// - Simultaneous wr_en and write-back
//   - Same address: the external write (reg_in) wins.
//   - Different addresses: both writes happen.
// - Read-during-write: an operand read in the same cycle as a write to that register returns the old value.
//   - The new value is visible from the next cycle.
// - Operand addresses may be equal (A==B), e.g. SUB gives 0 with zero=1.
// TESTING
// - Reset: hold rst=0 for 2 cycles with wr_en/en=1 -> all regs, out, carry, zero, valid = 0.
// - Write/read: write r0=5, r1=3 -> reg_out=5 at reg_addr=0 and 3 at reg_addr=1.
// - ALU ops on r0=5, r1=3, issuing en=1 with addr1=0, addr2=1, result one cycle later:
//   - ADD -> out=8, c=0, z=0, valid pulse
//   - SUB -> 2
//   - AND -> 1
//   - OR -> 7
//   - XOR -> 6
//   - NOT -> 10
//   - SHL -> 10
//   - SHR -> 2, c=1
// - Overflow and borrow:
//   - r0=15, r1=1: ADD -> out=0, c=1, z=1.
//   - r0=3, r1=5: SUB -> out=14, c=1, z=0.
// - Write-back conflict: en+wb_en to r2 and wr_en to r2 with reg_in=9 at the same edge -> r2=9.
//   - Repeat with wr_en to r3 -> r2=result and r3=9.
// - Hold and reset mid-operation:
//   - en=0 -> out stays, valid=0.
//   - rst=0 on the same edge as en=1 -> out=0, valid=0.

Source files
------------

// File: rtl/cpu_alu_regfile_if.sv
// Sequencer <-> datapath bus: register-file access, ALU issue/write-back and ALU result.
// Latency: none (wires only).
// Backpressure: none; the datapath accepts one access and one issue every cycle.
//
// Ports (signals carried):
//   wr_en, reg_addr, reg_in   external register write; reg_addr also selects reg_out
//   reg_out                   combinational read of reg[reg_addr]
//   op_addr_1, op_addr_2      operand A / B register addresses
//   en, opcode                ALU issue strobe and operation
//   wb_en, wb_addr            optional write-back of the ALU result (qualified by en)
//   out, carry, zero, valid   registered ALU result, flags and one-cycle update pulse
interface cpu_alu_regfile_if #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 2
);
    logic              wr_en;
    logic [ADDR_W-1:0] reg_addr;
    logic [DATA_W-1:0] reg_in;
    logic [DATA_W-1:0] reg_out;
    logic [ADDR_W-1:0] op_addr_1;
    logic [ADDR_W-1:0] op_addr_2;
    logic              en;
    logic [2:0]        opcode;
    logic              wb_en;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] out;
    logic              carry;
    logic              zero;
    logic              valid;

    // Sequencer side
    modport master (
        output wr_en, reg_addr, reg_in, op_addr_1, op_addr_2,
               en, opcode, wb_en, wb_addr,
        input  reg_out, out, carry, zero, valid
    );

    // Datapath side
    modport slave (
        input  wr_en, reg_addr, reg_in, op_addr_1, op_addr_2,
               en, opcode, wb_en, wb_addr,
        output reg_out, out, carry, zero, valid
    );
endinterface

// File: rtl/cpu_alu_regfile.sv
// Datapath core of the 8-bit CPU: REG_NUM x DATA_W register file plus registered ALU with write-back.
// Latency: reg_out combinational; out/carry/zero/valid update 1 cycle after an en issue.
// Backpressure: none; back-to-back issues give one result per cycle, valid pulses once per issue.
//
// Ports:
//   clk   rising-edge clock for all state
//   rst   synchronous active-low reset; clears registers, result, flags and valid
//   bus   cpu_alu_regfile_if.slave (register access, ALU issue, result)
module cpu_alu_regfile #(
    parameter int DATA_W  = 4,
    parameter int REG_NUM = 4,
    parameter int ADDR_W  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    cpu_alu_regfile_if.slave      bus
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    logic [DATA_W-1:0] regs [REG_NUM];

    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W:0]   ext;        // one extra bit to catch carry/borrow
    logic [DATA_W-1:0] result;
    logic              carry_nxt;

    logic [DATA_W-1:0] out_q;
    logic              carry_q;
    logic              zero_q;
    logic              valid_q;

    assign bus.reg_out = regs[bus.reg_addr];
    assign bus.out     = out_q;
    assign bus.carry   = carry_q;
    assign bus.zero    = zero_q;
    assign bus.valid   = valid_q;

    // Operands come straight from the array, so a write landing on the same
    // edge is not seen until the following cycle.
    always_comb begin
        op_a      = regs[bus.op_addr_1];
        op_b      = regs[bus.op_addr_2];
        ext       = '0;
        result    = '0;
        carry_nxt = 1'b0;
        case (bus.opcode)
            OP_ADD: begin
                ext       = {1'b0, op_a} + {1'b0, op_b};
                result    = ext[DATA_W-1:0];
                carry_nxt = ext[DATA_W];
            end
            OP_SUB: begin
                // Top bit of the widened difference is set exactly when A < B.
                ext       = {1'b0, op_a} - {1'b0, op_b};
                result    = ext[DATA_W-1:0];
                carry_nxt = ext[DATA_W];
            end
            OP_AND: result = op_a & op_b;
            OP_OR:  result = op_a | op_b;
            OP_XOR: result = op_a ^ op_b;
            OP_NOT: result = ~op_a;
            OP_SHL: begin
                result    = {op_a[DATA_W-2:0], 1'b0};
                carry_nxt = op_a[DATA_W-1];
            end
            OP_SHR: begin
                result    = {1'b0, op_a[DATA_W-1:1]};
                carry_nxt = op_a[0];
            end
            default: begin
                result    = '0;
                carry_nxt = 1'b0;
            end
        endcase
    end

    // Register file: write-back is issued first so that an external write to
    // the same register on the same edge overrides it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (bus.en && bus.wb_en) begin
                regs[bus.wb_addr] <= result;
            end
            if (bus.wr_en) begin
                regs[bus.reg_addr] <= bus.reg_in;
            end
        end
    end

    // Result/flags hold when idle; valid marks the cycle they changed.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= bus.en;
            if (bus.en) begin
                out_q   <= result;
                carry_q <= carry_nxt;
                zero_q  <= (result == '0);
            end
        end
    end

endmodule

// File: tb/tb_cpu_alu_regfile.sv
// Self-checking bench for cpu_alu_regfile: directed scenarios then random traffic against a behavioural model.
// Latency: checks outputs 1 ns after each rising edge.
// Backpressure: n/a.
module tb_cpu_alu_regfile;

    logic clk;
    logic rst;

    cpu_alu_regfile_if #(.DATA_W(4), .ADDR_W(2)) bus ();

    cpu_alu_regfile #(.DATA_W(4), .REG_NUM(4), .ADDR_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;

    // Behavioural model state
    int m_regs [4];
    int m_out;
    int m_c;
    int m_z;
    int m_v;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference ALU from the opcode table, using plain integer arithmetic.
    function automatic void ref_alu(input int op, input int a, input int b,
                                    output int res, output int c);
        c = 0;
        case (op)
            0: begin res = (a + b) % 16; c = (a + b >= 16) ? 1 : 0; end
            1: begin res = (a - b + 16) % 16; c = (a < b) ? 1 : 0; end
            2: res = a & b;
            3: res = a | b;
            4: res = a ^ b;
            5: res = 15 - a;
            6: begin res = (a * 2) % 16; c = (a >= 8) ? 1 : 0; end
            default: begin res = a / 2; c = a % 2; end
        endcase
    endfunction

    task automatic drive(input int wr, input int addr, input int din,
                         input int o1, input int o2, input int e, input int op,
                         input int wb, input int wba);
        bus.wr_en     = wr[0];
        bus.reg_addr  = addr[1:0];
        bus.reg_in    = din[3:0];
        bus.op_addr_1 = o1[1:0];
        bus.op_addr_2 = o2[1:0];
        bus.en        = e[0];
        bus.opcode    = op[2:0];
        bus.wb_en     = wb[0];
        bus.wb_addr   = wba[1:0];
    endtask

    task automatic check_regs(input string tag);
        logic [1:0] save;
        save = bus.reg_addr;
        for (int i = 0; i < 4; i++) begin
            bus.reg_addr = 2'(i);
            #0.5;
            chk($sformatf("%s_r%0d", tag, i), int'(bus.reg_out), m_regs[i]);
        end
        bus.reg_addr = save;
        #0.5;
    endtask

    // Advance one clock: update the model from the pre-edge inputs, then compare.
    task automatic step(input string tag);
        int a, b, res, c;
        a = m_regs[bus.op_addr_1];
        b = m_regs[bus.op_addr_2];
        ref_alu(int'(bus.opcode), a, b, res, c);
        if (!rst) begin
            for (int i = 0; i < 4; i++) m_regs[i] = 0;
            m_out = 0; m_c = 0; m_z = 0; m_v = 0;
        end else begin
            m_v = bus.en ? 1 : 0;
            if (bus.en) begin
                m_out = res; m_c = c; m_z = (res == 0) ? 1 : 0;
                if (bus.wb_en) m_regs[bus.wb_addr] = res;
            end
            if (bus.wr_en) m_regs[bus.reg_addr] = int'(bus.reg_in);
        end
        @(posedge clk);
        #1;
        chk({tag, "_out"},   int'(bus.out),   m_out);
        chk({tag, "_carry"}, int'(bus.carry), m_c);
        chk({tag, "_zero"},  int'(bus.zero),  m_z);
        chk({tag, "_valid"}, int'(bus.valid), m_v);
        check_regs(tag);
    endtask

    task automatic write_reg(input int addr, input int val);
        drive(1, addr, val, 0, 0, 0, 0, 0, 0);
        step("wr");
    endtask

    // Issue one ALU op on r0/r1 and also compare against hand-derived values.
    task automatic issue(input string tag, input int op, input int o1, input int o2,
                         input int exp_out, input int exp_c, input int exp_z);
        drive(0, 0, 0, o1, o2, 1, op, 0, 0);
        step(tag);
        chk({tag, "_k_out"},   int'(bus.out),   exp_out);
        chk({tag, "_k_carry"}, int'(bus.carry), exp_c);
        chk({tag, "_k_zero"},  int'(bus.zero),  exp_z);
        chk({tag, "_k_valid"}, int'(bus.valid), 1);
    endtask

    int exp_o [8] = '{8, 2, 1, 7, 6, 10, 10, 2};
    int exp_c [8] = '{0, 0, 0, 0, 0, 0, 0, 1};

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 4; i++) m_regs[i] = 0;
        m_out = 0; m_c = 0; m_z = 0; m_v = 0;

        // Reset held with every write/issue strobe active
        rst = 1'b0;
        drive(1, 2, 7, 0, 1, 1, 0, 1, 3);
        step("rst0");
        step("rst1");
        chk("rst_k_out", int'(bus.out), 0);
        chk("rst_k_valid", int'(bus.valid), 0);

        // Write/read
        rst = 1'b1;
        write_reg(0, 5);
        write_reg(1, 3);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 chk("rd_r0", int'(bus.reg_out), 5);
        bus.reg_addr = 2'd1;
        #1 chk("rd_r1", int'(bus.reg_out), 3);

        // All opcodes on r0=5, r1=3
        for (int op = 0; op < 8; op++) begin
            issue($sformatf("op%0d", op), op, 0, 1, exp_o[op], exp_c[op], 0);
        end
        drive(0, 0, 0, 0, 1, 0, 0, 1, 2);
        step("hold0");
        chk("hold0_k_valid", int'(bus.valid), 0);
        chk("hold0_k_out", int'(bus.out), 2);

        // Overflow and borrow
        write_reg(0, 15);
        write_reg(1, 1);
        issue("ovf", 0, 0, 1, 0, 1, 1);
        write_reg(0, 3);
        write_reg(1, 5);
        issue("brw", 1, 0, 1, 14, 1, 0);
        issue("same", 1, 0, 0, 0, 0, 1);

        // Write-back vs external write, same register: external wins
        drive(1, 2, 9, 0, 1, 1, 0, 1, 2);
        step("conf_same");
        bus.reg_addr = 2'd2;
        #1 chk("conf_same_k_r2", int'(bus.reg_out), 9);
        // Different registers: both land
        drive(1, 3, 9, 0, 1, 1, 0, 1, 2);
        step("conf_diff");
        bus.reg_addr = 2'd2;
        #1 chk("conf_diff_k_r2", int'(bus.reg_out), 8);
        bus.reg_addr = 2'd3;
        #1 chk("conf_diff_k_r3", int'(bus.reg_out), 9);

        // Read-during-write: operand sees old r0 (3)
        drive(1, 0, 1, 0, 1, 1, 0, 0, 0);
        step("rdw");
        chk("rdw_k_out", int'(bus.out), 8);

        // Hold, then reset on the same edge as an issue
        drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
        step("hold1");
        chk("hold1_k_out", int'(bus.out), 8);
        chk("hold1_k_valid", int'(bus.valid), 0);
        rst = 1'b0;
        drive(0, 0, 0, 0, 1, 1, 0, 0, 0);
        step("rst_mid");
        chk("rst_mid_k_out", int'(bus.out), 0);
        chk("rst_mid_k_valid", int'(bus.valid), 0);
        rst = 1'b1;

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 31) == 0) ? 1'b0 : 1'b1;
            drive(int'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3) != 0),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
                  int'($urandom_range(0, 3)));
            step("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
